// File: rtl/adder_seq_pkg.sv
// Shared constants for the multi-precision add sequencer.
// State encoding and the byte slice width used by the shared adder8.
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_if.sv
// Operand/result handshake bundle for adder_seq.
// The sub field exists only when ADDSEQ_SUB_EN is defined.
interface adder_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef ADDSEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    modport slave (
        input  in_valid, a, b, c_in,
`ifdef ADDSEQ_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );

    modport master (
        output in_valid, a, b, c_in,
`ifdef ADDSEQ_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );

endinterface

// File: rtl/adder8.sv
// Existing 8-bit ripple byte adder shared by the add sequencer.
module adder8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       c_out
);

    logic [8:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {8'd0, c_in};
    assign s     = total[7:0];
    assign c_out = total[8];

endmodule

// File: rtl/adder_seq.sv
// Multi-precision add sequencer: one adder8 walks NBYTES byte slices LSB-first.
// Define ADDSEQ_SUB_EN to add a subtract mode (bus.sub sampled at acceptance).
//
// state   | meaning
// ST_IDLE | waiting for an operation, in_ready high
// ST_RUN  | one byte slice per cycle, carry chained through carry_q
// ST_DONE | result held on sum/c_out until out_ready
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input logic        clk,
    input logic        rst_n,
    adder_seq_if.slave bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              carry_q;
    logic              sub_q;
    logic              sub_in;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      sum_q;
    logic              c_out_q;
    logic              accept;
    logic              last_byte;
    logic [BYTE_W-1:0] add_x;
    logic [BYTE_W-1:0] add_y;
    logic [BYTE_W-1:0] add_s;
    logic              add_c;

`ifdef ADDSEQ_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)        state_nxt = ST_RUN;
            ST_RUN:  if (last_byte)     state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        accept        = 1'b0;
        last_byte     = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
            end
            ST_RUN: begin
                bus.busy  = 1'b1;
                last_byte = (idx == IDX_LAST);
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract is A + ~B + 1: invert the B slice here, force the seed carry at acceptance.
    assign add_x = a_q[BYTE_W*idx +: BYTE_W];
    assign add_y = b_q[BYTE_W*idx +: BYTE_W] ^ {BYTE_W{sub_q}};

    adder8 u_adder8 (
        .x     (add_x),
        .y     (add_y),
        .c_in  (carry_q),
        .s     (add_s),
        .c_out (add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= sub_in;
            carry_q <= sub_in | bus.c_in;
            idx     <= '0;
        end else if (state == ST_RUN) begin
            sum_q[BYTE_W*idx +: BYTE_W] <= add_s;
            carry_q                     <= add_c;
            if (last_byte) begin
                idx     <= '0;
                c_out_q <= add_c;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: directed table, hand-written corner sequences,
// and randomized operations against a wide-arithmetic reference model.
module tb_adder_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sb;
        int           hold;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_seq_if #(.NBYTES(NB)) bus ();

    adder_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sb);
        if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_sub(input logic v);
`ifdef ADDSEQ_SUB_EN
        bus.sub = v;
`else
        if (v) $display("note: sub requested in an add-only build");
`endif
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb, input int hold,
                         output logic [W-1:0] rs, output logic rc);
        int guard;
        int lat;
        bus.a = a; bus.b = b; bus.c_in = cin; set_sub(sb);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        check({nm, " in_ready_wait"}, 64'(guard < 20), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = ~a; bus.b = $urandom; bus.c_in = ~cin; set_sub(1'b0);
        check({nm, " busy_run"}, 64'(bus.busy), 64'd1);
        check({nm, " in_ready_run"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check({nm, " latency"}, 64'(lat), 64'(NB));
        rs = bus.sum; rc = bus.c_out;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = (h == 0);
            bus.a = $urandom;
            @(posedge clk); #1;
            check({nm, " hold_sum"}, 64'(bus.sum), 64'(rs));
            check({nm, " hold_cout"}, 64'(bus.c_out), 64'(rc));
            check({nm, " hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({nm, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({nm, " valid_after_hs"}, 64'(bus.out_valid), 64'd0);
        check({nm, " in_ready_after_hs"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[$];
        logic [W-1:0] rs;
        logic         rc;
        logic [W:0]   m;
        logic [W-1:0] qa[2], qb[2], es[2];
        logic         ec[2];
        int           acc[2];
        int           k, r, cyc;
        logic         accept_now;

        vecs.push_back('{"carry_byte0", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h0000_0100, 1'b0});
        vecs.push_back('{"ripple_all",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"mixed_hold",  32'h80A0_007F, 32'h7F0B_00A0, 1'b0, 1'b0, 3, 32'hFFAB_011F, 1'b0});
        vecs.push_back('{"zero_cin",    32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1, 32'h0000_0001, 1'b0});
        vecs.push_back('{"max_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 1'b1});
`ifdef ADDSEQ_SUB_EN
        vecs.push_back('{"sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"sub_noborrow",32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, 32'h0000_0002, 1'b1});
`endif

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c_in = 1'b0; set_sub(1'b0);
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.c_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, vecs[i].hold, rs, rc);
            check({vecs[i].name, " sum"}, 64'(rs), 64'(vecs[i].esum));
            check({vecs[i].name, " cout"}, 64'(rc), 64'(vecs[i].ecout));
        end

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_extra_result", 64'(bus.out_valid), 64'd0);
        end

        // Abort in the middle of RUN.
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("mid_run_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0; #1;
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_sum", 64'(bus.sum), 64'd0);
        check("abort_cout", 64'(bus.c_out), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_op("after_rst", 32'd1, 32'd2, 1'b0, 1'b0, 0, rs, rc);
        check("after_rst sum", 64'(rs), 64'd3);
        check("after_rst cout", 64'(rc), 64'd0);

        // Back-to-back with the consumer always ready.
        qa[0] = 32'h1111_1111; qb[0] = 32'h2222_2222; es[0] = 32'h3333_3333; ec[0] = 1'b0;
        qa[1] = 32'hFFFF_FFFF; qb[1] = 32'h0000_0001; es[1] = 32'h0000_0000; ec[1] = 1'b1;
        acc[0] = 0; acc[1] = 0; k = 0; r = 0; cyc = 0;
        bus.out_ready = 1'b1;
        bus.a = qa[0]; bus.b = qb[0]; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        while (cyc < 40 && r < 2) begin
            if (bus.out_valid) begin
                check("b2b sum", 64'(bus.sum), 64'(es[r]));
                check("b2b cout", 64'(bus.c_out), 64'(ec[r]));
                r++;
            end
            accept_now = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (accept_now && k < 2) begin
                acc[k] = cyc;
                k++;
                if (k < 2) begin bus.a = qa[k]; bus.b = qb[k]; end
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("b2b results", 64'(r), 64'd2);
        check("b2b spacing", 64'(acc[1] - acc[0]), 64'(NB + 2));

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            logic rcin, rsb;
            ra = $urandom; rb = $urandom;
            if (i % 6 == 0) ra = '1;
            if (i % 6 == 1) rb = '1;
            rcin = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
            rsb = 1'($urandom_range(0, 1));
`else
            rsb = 1'b0;
`endif
            m = ref_add(ra, rb, rcin, rsb);
            do_op("rand", ra, rb, rcin, rsb, $urandom_range(0, 2), rs, rc);
            check("rand sum", 64'(rs), 64'(m[W-1:0]));
            check("rand cout", 64'(rc), 64'(m[W]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
